// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data memory responder.
package mips_mem_pkg;

    typedef logic [7:0] byte_t;

    // Lane 0 is the byte at the word's base address (most significant in the packed word).
    typedef byte_t [0:3] word_lanes_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } mem_state_e;

    localparam int LATENCY_MAX = 15;

    // Counter wide enough to hold LATENCY_MAX - 1.
    localparam int COUNT_W = $clog2(LATENCY_MAX + 1);

endpackage

// File: rtl/mips_byte_ram.sv
// Four byte-wide banks forming a word-organised RAM. Lane i lives in bank i,
// so a word access touches the same row in every bank.
module mips_byte_ram
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-3:0] index,
    input  word_lanes_t           wr_data,
    output word_lanes_t           rd_data
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bank
            byte_t bank [DEPTH];
            byte_t rd_reg;

            // Storage write: no reset so the array maps onto block RAM.
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    bank[index] <= wr_data[gi];
                end
            end

            // Registered read port; holds its value until the next read.
            always_ff @(posedge clk) begin
                if (!rst_b) begin
                    rd_reg <= '0;
                end else if (rd_en) begin
                    rd_reg <= bank[index];
                end
            end

            assign rd_data[gi] = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/mips_data_memory.sv
// Byte-addressed data memory with request/ready handshake and a fixed,
// configurable access latency. Misaligned or out-of-range requests are
// answered one cycle later with mem_fault and never touch the array.
module mips_data_memory
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        mem_req,
    input  logic        mem_write_en,
    input  logic [31:0] mem_addr,
    input  word_lanes_t mem_data_in,
    output word_lanes_t mem_data_out,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        mem_fault
);

    localparam logic [COUNT_W-1:0] COUNT_LOAD = COUNT_W'(LATENCY - 1);
    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(1);

    mem_state_e            state_reg;
    logic [COUNT_W-1:0]    count_reg;
    logic [ADDR_WIDTH-3:0] index_reg;
    logic                  write_reg;
    word_lanes_t           data_reg;
    logic                  ready_reg;
    logic                  fault_reg;

    logic                  req_fault;
    logic                  accept;
    logic                  commit_now;
    logic                  commit_wait;

    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_WIDTH-3:0] ram_index;
    word_lanes_t           ram_wdata;

    // A request is rejected if it is not word aligned or lies beyond the backed storage.
    assign req_fault   = (mem_addr[1:0] != 2'b00) || ((mem_addr >> ADDR_WIDTH) != 32'd0);
    assign accept      = (state_reg == IDLE) && mem_req;
    // With single-cycle latency the access happens on the accept edge itself.
    assign commit_now  = accept && !req_fault && (LATENCY == 1);
    assign commit_wait = (state_reg == WAIT) && (count_reg == COUNT_LAST);

    // Route either the live request or the latched one to the RAM; reset blocks any commit.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_index = index_reg;
        ram_wdata = data_reg;
        if (commit_now) begin
            ram_we    = mem_write_en;
            ram_re    = !mem_write_en;
            ram_index = mem_addr[ADDR_WIDTH-1:2];
            ram_wdata = mem_data_in;
        end else if (commit_wait) begin
            ram_we = write_reg;
            ram_re = !write_reg;
        end
        if (!rst_b) begin
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
    end

    // Control FSM: accept in IDLE, count down in WAIT, pulse ready/fault in DONE.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_reg <= IDLE;
            count_reg <= '0;
            ready_reg <= 1'b0;
            fault_reg <= 1'b0;
        end else begin
            ready_reg <= 1'b0;
            fault_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (mem_req) begin
                        index_reg <= mem_addr[ADDR_WIDTH-1:2];
                        write_reg <= mem_write_en;
                        data_reg  <= mem_data_in;
                        if (req_fault) begin
                            state_reg <= DONE;
                            ready_reg <= 1'b1;
                            fault_reg <= 1'b1;
                        end else if (LATENCY == 1) begin
                            state_reg <= DONE;
                            ready_reg <= 1'b1;
                        end else begin
                            count_reg <= COUNT_LOAD;
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    count_reg <= count_reg - COUNT_W'(1);
                    if (count_reg == COUNT_LAST) begin
                        state_reg <= DONE;
                        ready_reg <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    mips_byte_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_b   (rst_b),
        .wr_en   (ram_we),
        .rd_en   (ram_re),
        .index   (ram_index),
        .wr_data (ram_wdata),
        .rd_data (mem_data_out)
    );

    assign mem_ready = ready_reg;
    assign mem_fault = fault_reg;
    assign mem_busy  = (state_reg != IDLE);

endmodule
